// File: rtl/excess3_to_bcd_stream.sv
// Excess-3 digit stream to packed BCD word converter with valid/ready on both sides.
// Invalid codes decode to nibble F and are flagged per digit in err_mask.
module excess3_to_bcd_stream #(
  parameter int NDIGITS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [3:0]                     e3_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [4*NDIGITS-1:0]           bcd_out,
  output logic                           err,
  output logic [NDIGITS-1:0]             err_mask,
  output logic [$clog2(NDIGITS+1)-1:0]   digit_cnt
);

  localparam int CW = $clog2(NDIGITS + 1);
  localparam logic [CW-1:0] LAST = CW'(NDIGITS - 1);

  // state   | meaning
  // COLLECT | accepting digits into the shadow word
  // HOLD    | word presented on the output, waiting for out_ready
  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [4*NDIGITS-1:0] sh_word, word_nxt;
  logic [NDIGITS-1:0]   sh_mask, mask_nxt;
  logic [3:0]           digit;
  logic                 code_bad;
  logic                 accept;
  logic                 last;

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == HOLD);

  always_comb begin
    code_bad = (e3_in < 4'h3) || (e3_in > 4'hC);
    digit    = code_bad ? 4'hF : (e3_in - 4'd3);
    word_nxt = {sh_word[4*NDIGITS-5:0], digit};
    mask_nxt = {sh_mask[NDIGITS-2:0], code_bad};
    // clr wins over a digit presented in the same cycle
    accept   = in_valid && in_ready && !clr;
    last     = accept && (digit_cnt == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (last)      state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = COLLECT;
      default:                state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_word   <= '0;
      sh_mask   <= '0;
      digit_cnt <= '0;
      bcd_out   <= '0;
      err       <= 1'b0;
      err_mask  <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (clr) begin
            sh_word   <= '0;
            sh_mask   <= '0;
            digit_cnt <= '0;
          end else if (accept) begin
            sh_word <= word_nxt;
            sh_mask <= mask_nxt;
            if (last) begin
              bcd_out   <= word_nxt;
              err_mask  <= mask_nxt;
              err       <= |mask_nxt;
              digit_cnt <= '0;
            end else begin
              digit_cnt <= digit_cnt + CW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            sh_word <= '0;
            sh_mask <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_excess3_to_bcd_stream.sv
// Directed bench for excess3_to_bcd_stream (NDIGITS = 4), expected words hand-computed.
module tb_excess3_to_bcd_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  e3_in = 4'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] bcd_out;
  logic        err;
  logic [3:0]  err_mask;
  logic [2:0]  digit_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  excess3_to_bcd_stream #(.NDIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .e3_in     (e3_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_out   (bcd_out),
    .err       (err),
    .err_mask  (err_mask),
    .digit_cnt (digit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [3:0] code);
    in_valid = 1'b1;
    e3_in    = code;
    step();
    in_valid = 1'b0;
  endtask

  task automatic feed4(input logic [15:0] codes);
    for (int i = 3; i >= 0; i--) feed(codes[4*i +: 4]);
  endtask

  // Called right after the 4th accept edge; with out_ready high the word lasts one cycle.
  task automatic check_word(input string tag, input logic [15:0] exp_bcd, input logic [3:0] exp_mask);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".bcd"},       32'(bcd_out),   32'(exp_bcd));
    check({tag, ".err"},       32'(err),       32'(|exp_mask));
    check({tag, ".mask"},      32'(err_mask),  32'(exp_mask));
    check({tag, ".cnt"},       32'(digit_cnt), 32'd0);
    step();
    check({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, ".ready_back"}, 32'(in_ready),  32'd1);
  endtask

  logic [15:0] held;

  initial begin
    #12;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.in_ready",  32'(in_ready),  32'd1);
    check("rst.bcd",       32'(bcd_out),   32'd0);
    check("rst.err",       32'(err),       32'd0);
    check("rst.mask",      32'(err_mask),  32'd0);
    check("rst.cnt",       32'(digit_cnt), 32'd0);
    rst_n = 1'b1;
    step();

    // basic word
    feed(4'h7);
    feed(4'h8);
    check("basic.cnt2", 32'(digit_cnt), 32'd2);
    feed(4'h9);
    check("basic.pre_valid", 32'(out_valid), 32'd0);
    feed(4'hA);
    check_word("basic", 16'h4567, 4'b0000);

    // one invalid digit in position 2
    feed4(16'h3C26);
    check_word("err", 16'h09F3, 4'b0010);

    // backpressure
    out_ready = 1'b0;
    feed4(16'h4444);
    held = bcd_out;
    check("bp.word", 32'(held), 32'h1111);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      e3_in    = 4'h9;
      check("bp.valid", 32'(out_valid), 32'd1);
      check("bp.ready", 32'(in_ready),  32'd0);
      check("bp.bcd",   32'(bcd_out),   32'h1111);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp.still_valid", 32'(out_valid), 32'd1);
    step();
    check("bp.valid_drop", 32'(out_valid), 32'd0);
    check("bp.ready_back", 32'(in_ready),  32'd1);
    check("bp.cnt_clean",  32'(digit_cnt), 32'd0);

    // clr drops the partial frame and the concurrent digit
    feed(4'h9);
    feed(4'h9);
    clr      = 1'b1;
    in_valid = 1'b1;
    e3_in    = 4'h5;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr.cnt", 32'(digit_cnt), 32'd0);
    feed4(16'h4567);
    check_word("clr", 16'h1234, 4'b0000);

    // async reset mid-frame
    feed(4'h5);
    feed(4'h6);
    feed(4'h7);
    #2 rst_n = 1'b0;
    #1;
    check("arst1.cnt",   32'(digit_cnt), 32'd0);
    check("arst1.bcd",   32'(bcd_out),   32'd0);
    check("arst1.ready", 32'(in_ready),  32'd1);
    #1 rst_n = 1'b1;
    step();
    feed4(16'hCBA9);
    check_word("arst1.next", 16'h9876, 4'b0000);

    // async reset mid-hold
    out_ready = 1'b0;
    feed4(16'h0333);
    check("arst2.valid_pre", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst2.valid", 32'(out_valid), 32'd0);
    check("arst2.ready", 32'(in_ready),  32'd1);
    check("arst2.bcd",   32'(bcd_out),   32'd0);
    check("arst2.err",   32'(err),       32'd0);
    check("arst2.mask",  32'(err_mask),  32'd0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    feed4(16'h3456);
    check_word("arst2.next", 16'h0123, 4'b0000);

    // sweep all 16 codes
    feed4(16'h0123);
    check_word("sweep0", 16'hFFF0, 4'b1110);
    feed4(16'h4567);
    check_word("sweep1", 16'h1234, 4'b0000);
    feed4(16'h89AB);
    check_word("sweep2", 16'h5678, 4'b0000);
    feed4(16'hCDEF);
    check_word("sweep3", 16'h9FFF, 4'b0111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
